button_reader: RTL



---
 rtl/button_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/button_reader.sv
// Debounced push-button reader: two-flop synchroniser, cycle-count bounce
// filter, clean level plus one-cycle press/release/long-press strobes and a
// wrapping press counter.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   btn_in         - raw asynchronous button pin
//   btn_level      - debounced state, 1 = pressed
//   press_pulse    - one-cycle strobe on accepted press
//   release_pulse  - one-cycle strobe on accepted release
//   long_pulse     - one-cycle strobe after a press held LONG_CYCLES
//   press_count    - accepted presses, modulo 256
module button_reader #(
    parameter int unsigned DEB_CYCLES     = 500000,
    parameter int unsigned LONG_CYCLES    = 50000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned CNT_W = 26;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic             act;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             done_q, done_d;
    logic [7:0]       count_d;
    logic             press_d, release_d, long_d, level_d;

    // Synchroniser; resets to the inactive pin level so reset never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{BTN_ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    assign act = sync_q[1] ^ BTN_ACTIVE_LOW;

    // State register plus counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            deb_q         <= '0;
            hold_q        <= '0;
            done_q        <= 1'b0;
            press_count   <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            btn_level     <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_q         <= deb_d;
            hold_q        <= hold_d;
            done_q        <= done_d;
            press_count   <= count_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            btn_level     <= level_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (act) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!act)                  state_d = IDLE;
                else if (deb_q == DEB_LAST) state_d = HELD;
            end
            HELD: begin
                if (!act) state_d = DEB_RELEASE;
            end
            DEB_RELEASE: begin
                if (act)                   state_d = HELD;
                else if (deb_q == DEB_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter updates and next values of the registered outputs
    always_comb begin
        deb_d     = deb_q;
        hold_d    = hold_q;
        done_d    = done_q;
        count_d   = press_count;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (act) deb_d = '0;
            end
            DEB_PRESS: begin
                if (act) begin
                    if (deb_q == DEB_LAST) begin
                        press_d = 1'b1;
                        count_d = press_count + 8'd1;
                        hold_d  = '0;
                        done_d  = 1'b0;
                    end else begin
                        deb_d = deb_q + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (!act) begin
                    deb_d = '0;
                end else if (hold_q == LONG_LAST) begin
                    // Saturated: fire once, then stay silent until the next press
                    if (!done_q) begin
                        long_d = 1'b1;
                        done_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            DEB_RELEASE: begin
                // hold_q and done_q are left untouched so a bounce back to HELD resumes the hold
                if (!act) begin
                    if (deb_q == DEB_LAST) release_d = 1'b1;
                    else                   deb_d = deb_q + CNT_W'(1);
                end
            end
            default: begin
                deb_d = '0;
            end
        endcase
    end

    assign level_d = (state_d == HELD) || (state_d == DEB_RELEASE);

endmodule
